gemm_matrix_loader: RTL and testbench

//  Upstream feeder for gemm_pipeline: accepts a serial valid/ready stream of W-bit elements, A then B,
//  row-major, and assembles them into the flat N*N*W-bit operand buses arg0 (A) and arg1 (B).

---
 rtl/gemm_matrix_loader.sv | 103 ++++++++++
 tb/tb_gemm_matrix_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_matrix_loader.sv
// Serial-to-parallel operand loader for gemm_pipeline: streams A then B
// row-major into flat N*N*W buses and presents them with valid/ready.
module gemm_matrix_loader #(
  parameter int N = 32,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [N*N*W-1:0] arg0,
  output logic [N*N*W-1:0] arg1,
  output logic           mat_valid,
  input  logic           mat_ready,
  output logic           load_b
);

  localparam int NN = N * N;
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IW-1:0] LAST = IW'(NN - 1);

  typedef enum logic [1:0] {
    S_LOAD_A = 2'd0,
    S_LOAD_B = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_idx;
  logic [NN*W-1:0] r_arg0;
  logic [NN*W-1:0] r_arg1;
  logic            w_accept;
  logic            w_last;
  logic [NN-1:0]   w_we_a;
  logic [NN-1:0]   w_we_b;

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_idx == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_LOAD_A;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_LOAD_A: if (w_accept && w_last) w_next = S_LOAD_B;
      S_LOAD_B: if (w_accept && w_last) w_next = S_HOLD;
      S_HOLD:   if (mat_ready)          w_next = S_LOAD_A;
      default:                          w_next = S_LOAD_A;
    endcase
    if (flush) w_next = S_LOAD_A;
  end

  always_comb begin
    in_ready  = 1'b0;
    mat_valid = 1'b0;
    load_b    = 1'b0;
    unique case (r_state)
      S_LOAD_A: in_ready = 1'b1;
      S_LOAD_B: begin
        in_ready = 1'b1;
        load_b   = 1'b1;
      end
      S_HOLD:   mat_valid = 1'b1;
      default:  in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_idx <= '0;
    else if (flush)    r_idx <= '0;
    else if (w_accept) r_idx <= w_last ? '0 : r_idx + 1'b1;
  end

  // One-hot word enables; B is state-gated so A and B never share a cycle
  for (genvar k = 0; k < NN; k++) begin : g_dec
    assign w_we_a[k] = w_accept & ~flush & (r_state == S_LOAD_A)
                     & (r_idx == IW'(k));
    assign w_we_b[k] = w_accept & ~flush & (r_state == S_LOAD_B)
                     & (r_idx == IW'(k));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arg0 <= '0;
      r_arg1 <= '0;
    end else begin
      for (int k = 0; k < NN; k++) begin
        if (w_we_a[k]) r_arg0[k*W +: W] <= in_data;
        if (w_we_b[k]) r_arg1[k*W +: W] <= in_data;
      end
    end
  end

  assign arg0 = r_arg0;
  assign arg1 = r_arg1;

endmodule

// File: tb/tb_gemm_matrix_loader.sv
// Directed bench for gemm_matrix_loader: 2x2 scoreboard checks plus
// a 32x32 corner-pattern run.
module tb_gemm_matrix_loader;

  localparam int W  = 32;
  localparam int BN = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [4*W-1:0] arg0;
  logic [4*W-1:0] arg1;
  logic          mat_valid;
  logic          mat_ready;
  logic          load_b;

  logic [W-1:0]        b_data;
  logic                b_valid;
  logic                b_in_ready;
  logic [BN*BN*W-1:0]  b_arg0;
  logic [BN*BN*W-1:0]  b_arg1;
  logic                b_mat_valid;
  logic                b_mat_ready;
  logic                b_load_b;
  logic                b_flush;

  int unsigned cyc = 0;
  int comps = 0;
  int fails = 0;
  logic [W-1:0] sb[$];

  gemm_matrix_loader #(.N(2), .W(W)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .arg0(arg0), .arg1(arg1),
    .mat_valid(mat_valid), .mat_ready(mat_ready), .load_b(load_b)
  );

  gemm_matrix_loader #(.N(BN), .W(W)) u_big (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_data(b_data), .in_valid(b_valid), .in_ready(b_in_ready),
    .arg0(b_arg0), .arg1(b_arg1),
    .mat_valid(b_mat_valid), .mat_ready(b_mat_ready), .load_b(b_load_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    comps++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push expected word, then hold in_valid until the element is taken
  task automatic send(input logic [W-1:0] d);
    int n;
    sb.push_back(d);
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'd1, 64'd0);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!mat_valid && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("valid_timeout", 64'd1, 64'd0);
  endtask

  task automatic check_pair(input string tag);
    logic [W-1:0] e;
    chk({tag, "_mat_valid"}, 64'(mat_valid), 64'd1);
    if (sb.size() != 8) chk({tag, "_sb_size"}, 64'(sb.size()), 64'd8);
    for (int i = 0; i < 8 && sb.size() > 0; i++) begin
      e = sb.pop_front();
      if (i < 4) chk($sformatf("%s_a%0d", tag, i),
                     64'(arg0[i*W +: W]), 64'(e));
      else       chk($sformatf("%s_b%0d", tag, i - 4),
                     64'(arg1[(i-4)*W +: W]), 64'(e));
    end
  endtask

  task automatic handshake();
    mat_ready = 1'b1;
    step();
    mat_ready = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    sb.delete();
  endtask

  initial begin
    int unsigned h;
    rst = 1'b1; flush = 1'b0; in_data = '0; in_valid = 1'b0;
    mat_ready = 1'b0;
    b_data = '0; b_valid = 1'b0; b_mat_ready = 1'b0; b_flush = 1'b0;
    #12;
    chk("rst_arg0", 64'(arg0 != '0), 64'd0);
    chk("rst_mat_valid", 64'(mat_valid), 64'd0);
    chk("rst_load_b", 64'(load_b), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // 1: constant stream, in_valid held high
    for (int k = 0; k < 8; k++) send(k < 4 ? 32'd1 : 32'd2);
    check_pair("t1");
    handshake();
    chk("t1_mv_after_hs", 64'(mat_valid), 64'd0);
    chk("t1_rdy_after_hs", 64'(in_ready), 64'd1);

    // 2: gapped stream, load_b window
    for (int k = 1; k <= 8; k++) begin
      send(32'(k));
      chk($sformatf("t2_load_b_%0d", k), 64'(load_b),
          64'(k >= 4 && k < 8));
      chk($sformatf("t2_mv_%0d", k), 64'(mat_valid), 64'(k == 8));
      step();
    end
    check_pair("t2");

    // 3: HOLD ignores input
    in_valid = 1'b1;
    in_data  = 32'd9;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_in_ready", 64'(in_ready), 64'd0);
      chk("t3_mat_valid", 64'(mat_valid), 64'd1);
    end
    in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) sb.push_back(32'(k));
    check_pair("t3");

    // 4: back-to-back second pair
    h = cyc;
    handshake();
    for (int k = 0; k < 8; k++) send(k < 4 ? 32'd3 : 32'd4);
    wait_valid();
    chk("t4_latency", 64'(cyc - h), 64'd9);
    check_pair("t4");
    handshake();

    // 5: flush mid-stream
    for (int k = 0; k < 6; k++) send(32'hA0 + 32'(k));
    do_flush();
    chk("t5_load_b_after_flush", 64'(load_b), 64'd0);
    for (int k = 5; k <= 12; k++) send(32'(k));
    wait_valid();
    check_pair("t5");
    flush = 1'b1;
    mat_ready = 1'b1;
    step();
    flush = 1'b0;
    mat_ready = 1'b0;
    chk("t5b_in_ready", 64'(in_ready), 64'd1);
    chk("t5b_mat_valid", 64'(mat_valid), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      send(32'(20 + k));
      chk($sformatf("t5b_load_b_%0d", k), 64'(load_b), 64'(k == 4));
    end
    for (int k = 5; k <= 8; k++) send(32'(20 + k));
    wait_valid();
    check_pair("t5b");
    handshake();

    // 6: async reset mid-cycle
    for (int k = 0; k < 5; k++) send(32'hB0 + 32'(k));
    #3;
    rst = 1'b1;
    #1;
    chk("t6_arg0_zero", 64'(arg0 != '0), 64'd0);
    chk("t6_arg1_zero", 64'(arg1 != '0), 64'd0);
    chk("t6_mat_valid", 64'(mat_valid), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    step();
    for (int k = 0; k < 8; k++) send(32'h40 + 32'(k));
    wait_valid();
    check_pair("t6");

    // 6b: N=32 corner pattern
    b_valid = 1'b1;
    for (int k = 0; k < 2 * BN * BN; k++) begin
      int r, c;
      r = (k % (BN * BN)) / BN;
      c = k % BN;
      if (r < 2 && c < 2) b_data = (k < BN * BN) ? 32'd1 : 32'd2;
      else                b_data = 32'd0;
      step();
    end
    b_valid = 1'b0;
    chk("big_mat_valid", 64'(b_mat_valid), 64'd1);
    chk("big_a11", 64'(b_arg0[1087:1056]), 64'd1);
    chk("big_b10", 64'(b_arg1[1055:1024]), 64'd2);
    chk("big_a00", 64'(b_arg0[31:0]), 64'd1);
    chk("big_a02", 64'(b_arg0[95:64]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end

endmodule
